// File: rtl/irq_ctrl_pkg.sv
// Shared constants and types for the interrupt aggregator.
// Register offsets, source IDs and the gateway state encoding.
package irq_ctrl_pkg;

  localparam logic [31:0] IRQ_PENDING = 32'h0;
  localparam logic [31:0] IRQ_ENABLE  = 32'h4;
  localparam logic [31:0] IRQ_CLAIM   = 32'h8;
  localparam logic [31:0] IRQ_MSIP    = 32'hC;

  localparam int IRQ_ID_NONE  = 0;
  localparam int IRQ_ID_TIMER = 1;
  localparam int IRQ_ID_SOFT  = 2;
  localparam int IRQ_ID_EXT0  = 3;

  typedef enum logic [1:0] {
    GW_IDLE,
    GW_PEND,
    GW_CLAIMED
  } gw_state_t;

endpackage

// File: rtl/axi4bus.sv
// Register-access bus shared with the machine timer.
// Single-beat address/data/response channels with valid/ready.
interface AXI4bus #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic          wvalid;
  logic          wready;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready;
  logic [AW-1:0] araddr;
  logic          arvalid;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rvalid;
  logic          rready;

  modport Slave (
    input  awaddr, awvalid, wdata, wvalid,
    input  bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid,
    output arready, rdata, rresp, rvalid
  );

  modport Master (
    output awaddr, awvalid, wdata, wvalid,
    output bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid,
    input  arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/irq_gateway.sv
// Per-source gateway: IDLE -> PEND -> CLAIMED with one-deep replay.
// EDGE=1 sources remember an edge seen while CLAIMED.
module irq_gateway
  import irq_ctrl_pkg::*;
#(
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic claim,
  input  logic complete,
  output logic pend
);

  gw_state_t state;
  logic      replay;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= GW_IDLE;
      replay <= 1'b0;
    end else begin
      unique case (state)
        GW_IDLE: if (req) state <= GW_PEND;
        GW_PEND: begin
          // claim beats a same-cycle request
          if (claim) begin
            state  <= GW_CLAIMED;
            replay <= EDGE && req;
          end
        end
        GW_CLAIMED: begin
          if (complete) begin
            state  <= (replay || (EDGE && req))
                      ? GW_PEND : GW_IDLE;
            replay <= 1'b0;
          end else if (EDGE && req) begin
            replay <= 1'b1;
          end
        end
        default: state <= GW_IDLE;
      endcase
    end
  end

  assign pend = (state == GW_PEND);

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt aggregator: gateways, fixed priority, claim/complete regs.
// Define IRQ_SYNC_EN to add 2-flop synchronizers on ExtIrq.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter logic [31:0] addrBase = 32'h0,
  parameter int          NUM_EXT  = 8,
  parameter int          ID_W     = 5
) (
  input  logic               Clk,
  input  logic               Rst,
  AXI4bus.Slave              axiBus,
  input  logic               TimerInt,
  input  logic [NUM_EXT-1:0] ExtIrq,
  output logic               IntReq,
  output logic [ID_W-1:0]    IntId
);

  localparam int NSRC = NUM_EXT + 3;

  logic [NUM_EXT-1:0] ext_s;
  logic [NUM_EXT-1:0] ext_d1;
  logic [NUM_EXT-1:0] ext_d2;
  logic [NSRC-1:1]    req;
  logic [NSRC-1:1]    claim;
  logic [NSRC-1:1]    complete;
  logic [NSRC-1:0]    pending;
  logic [NSRC-1:0]    enable;
  logic [NSRC-1:0]    masked;
  logic [ID_W-1:0]    sel;
  logic               msip;
  logic [31:0]        aw_lat;
  logic [31:0]        waddr;
  logic [31:0]        wr_off;
  logic [31:0]        rd_off;
  logic [31:0]        rd_mux;
  logic               rd_claim;
  logic               wr_claim;
  logic               wready_q;
  logic               bvalid_q;
  logic               rvalid_q;
  logic [31:0]        rdata_q;

`ifdef IRQ_SYNC_EN
  logic [NUM_EXT-1:0] sync1;
  logic [NUM_EXT-1:0] sync2;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= ExtIrq;
      sync2 <= sync1;
    end
  end

  assign ext_s = sync2;
`else
  assign ext_s = ExtIrq;
`endif

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ext_d1 <= '0;
      ext_d2 <= '0;
    end else begin
      ext_d1 <= ext_s;
      ext_d2 <= ext_d1;
    end
  end

  always_comb begin
    req = '0;
    req[IRQ_ID_TIMER] = TimerInt;
    req[IRQ_ID_SOFT]  = msip;
    req[NSRC-1:IRQ_ID_EXT0] = ext_d1 & ~ext_d2;
  end

  assign waddr    = axiBus.awvalid ? axiBus.awaddr : aw_lat;
  assign wr_off   = waddr - addrBase;
  assign rd_off   = axiBus.araddr - addrBase;
  assign rd_claim = axiBus.arvalid && (rd_off == IRQ_CLAIM);
  assign wr_claim = axiBus.wvalid && (wr_off == IRQ_CLAIM);

  assign pending[IRQ_ID_NONE] = 1'b0;

  for (genvar g = 1; g < NSRC; g++) begin : g_gw
    assign claim[g] = rd_claim && (IntId == ID_W'(g));
    assign complete[g] = wr_claim &&
      (axiBus.wdata[ID_W-1:0] == ID_W'(g));

    irq_gateway #(
      .EDGE (g >= IRQ_ID_EXT0)
    ) u_gw (
      .clk      (Clk),
      .rst      (Rst),
      .req      (req[g]),
      .claim    (claim[g]),
      .complete (complete[g]),
      .pend     (pending[g])
    );
  end

  assign masked = pending & enable;

  // lowest ID wins, so scan downwards and let the last hit stick
  always_comb begin
    sel = '0;
    for (int i = NSRC - 1; i >= 1; i--) begin
      if (masked[i]) sel = ID_W'(i);
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      IntReq <= 1'b0;
      IntId  <= '0;
    end else begin
      IntReq <= |masked;
      IntId  <= sel;
    end
  end

  always_comb begin
    rd_mux = '0;
    unique case (rd_off)
      IRQ_PENDING: rd_mux = 32'(pending);
      IRQ_ENABLE:  rd_mux = 32'(enable);
      IRQ_CLAIM:   rd_mux = 32'(IntId);
      IRQ_MSIP:    rd_mux = {31'd0, msip};
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      enable   <= '0;
      msip     <= 1'b0;
      aw_lat   <= '0;
      wready_q <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (axiBus.awvalid) aw_lat <= axiBus.awaddr;
      wready_q <= axiBus.wvalid;
      if (axiBus.wvalid) bvalid_q <= 1'b1;
      else if (axiBus.bready) bvalid_q <= 1'b0;
      if (axiBus.arvalid) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_mux;
      end else if (axiBus.rready) begin
        rvalid_q <= 1'b0;
      end
      if (axiBus.wvalid && (wr_off == IRQ_ENABLE))
        enable <= {axiBus.wdata[NSRC-1:1], 1'b0};
      if (axiBus.wvalid && (wr_off == IRQ_MSIP))
        msip <= axiBus.wdata[0];
    end
  end

  assign axiBus.awready = 1'b1;
  assign axiBus.arready = 1'b1;
  assign axiBus.wready  = wready_q;
  assign axiBus.bvalid  = bvalid_q;
  assign axiBus.bresp   = 2'b00;
  assign axiBus.rvalid  = rvalid_q;
  assign axiBus.rdata   = rdata_q;
  assign axiBus.rresp   = 2'b00;

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_irq_ctrl;
  import irq_ctrl_pkg::*;

  localparam int NUM_EXT = 8;
  localparam int ID_W = 5;
  localparam logic [31:0] BASE = 32'h1000;
`ifdef IRQ_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic timer_int = 1'b0;
  logic [NUM_EXT-1:0] ext_irq = '0;
  logic int_req;
  logic [ID_W-1:0] int_id;
  logic [31:0] d;
  int n_cmp = 0;
  int n_bad = 0;

  AXI4bus bus ();

  irq_ctrl #(
    .addrBase (BASE),
    .NUM_EXT  (NUM_EXT),
    .ID_W     (ID_W)
  ) dut (
    .Clk      (clk),
    .Rst      (rst),
    .axiBus   (bus),
    .TimerInt (timer_int),
    .ExtIrq   (ext_irq),
    .IntReq   (int_req),
    .IntId    (int_id)
  );

  always #5 clk = ~clk;

  task automatic axi_write(input logic [31:0] off,
                           input logic [31:0] data);
    bus.awaddr = BASE + off;
    bus.awvalid = 1'b1;
    bus.wdata = data;
    bus.wvalid = 1'b1;
    @(negedge clk);
    bus.awvalid = 1'b0;
    bus.wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] off,
                          output logic [31:0] data);
    bus.araddr = BASE + off;
    bus.arvalid = 1'b1;
    @(negedge clk);
    data = bus.rdata;
    bus.arvalid = 1'b0;
  endtask

  task automatic test_reset;
    n_cmp++;
    if (int_req !== 1'b0 || int_id !== '0) begin
      $display("FAIL rst_out got %0b/%0d want 0/0", int_req, int_id);
      n_bad++;
    end
    n_cmp++;
    if ({bus.rvalid, bus.bvalid, bus.wready} !== 3'b000) begin
      $display("FAIL rst_axi got %b want 000",
               {bus.rvalid, bus.bvalid, bus.wready});
      n_bad++;
    end
    n_cmp++;
    if ({bus.awready, bus.arready} !== 2'b11) begin
      $display("FAIL rst_ready got %b want 11",
               {bus.awready, bus.arready});
      n_bad++;
    end
    axi_read(IRQ_PENDING, d);
    n_cmp++;
    if (d !== 32'h0) begin
      $display("FAIL rst_pending got %0h want 0", d);
      n_bad++;
    end
  endtask

  task automatic test_timer;
    axi_write(IRQ_ENABLE, 32'h2);
    timer_int = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b0) begin
      $display("FAIL tmr_early got %0b want 0", int_req);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 5'd1) begin
      $display("FAIL tmr_req got %0b/%0d want 1/1", int_req, int_id);
      n_bad++;
    end
    axi_read(IRQ_PENDING, d);
    n_cmp++;
    if (d !== 32'h2) begin
      $display("FAIL tmr_pending got %0h want 2", d);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.rvalid !== 1'b0) begin
      $display("FAIL tmr_rv_pre got %0b want 0", bus.rvalid);
      n_bad++;
    end
    axi_read(IRQ_CLAIM, d);
    n_cmp++;
    if (d !== 32'h1 || bus.rvalid !== 1'b1) begin
      $display("FAIL tmr_claim got %0h/%0b want 1/1", d, bus.rvalid);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b0) begin
      $display("FAIL tmr_after_claim got %0b want 0", int_req);
      n_bad++;
    end
    axi_write(IRQ_CLAIM, 32'h1);
    n_cmp++;
    if (bus.bvalid !== 1'b1 || bus.wready !== 1'b1) begin
      $display("FAIL tmr_bresp got %0b/%0b want 1/1",
               bus.bvalid, bus.wready);
      n_bad++;
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 5'd1) begin
      $display("FAIL tmr_repend got %0b/%0d want 1/1", int_req, int_id);
      n_bad++;
    end
    axi_read(IRQ_CLAIM, d);
    n_cmp++;
    if (d !== 32'h1) begin
      $display("FAIL tmr_claim2 got %0h want 1", d);
      n_bad++;
    end
  endtask

  task automatic test_reset_mid_claim;
    rst = 1'b1;
    timer_int = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (int_req !== 1'b0 || int_id !== '0) begin
      $display("FAIL rmc_out got %0b/%0d want 0/0", int_req, int_id);
      n_bad++;
    end
    axi_read(IRQ_PENDING, d);
    n_cmp++;
    if (d !== 32'h0) begin
      $display("FAIL rmc_pending got %0h want 0", d);
      n_bad++;
    end
    axi_read(IRQ_ENABLE, d);
    n_cmp++;
    if (d !== 32'h0) begin
      $display("FAIL rmc_enable got %0h want 0", d);
      n_bad++;
    end
  endtask

  task automatic test_priority;
    axi_write(IRQ_ENABLE, 32'h1C);
    ext_irq[0] = 1'b1;
    axi_write(IRQ_MSIP, 32'h1);
    repeat (LAT + 1) @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 5'd2) begin
      $display("FAIL pri_first got %0b/%0d want 1/2", int_req, int_id);
      n_bad++;
    end
    axi_read(IRQ_MSIP, d);
    n_cmp++;
    if (d !== 32'h1) begin
      $display("FAIL pri_msip got %0h want 1", d);
      n_bad++;
    end
    axi_read(IRQ_CLAIM, d);
    n_cmp++;
    if (d !== 32'h2) begin
      $display("FAIL pri_claim got %0h want 2", d);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (int_id !== 5'd3) begin
      $display("FAIL pri_next got %0d want 3", int_id);
      n_bad++;
    end
    axi_read(IRQ_CLAIM, d);
    n_cmp++;
    if (d !== 32'h3) begin
      $display("FAIL pri_claim3 got %0h want 3", d);
      n_bad++;
    end
    ext_irq[0] = 1'b0;
    axi_write(IRQ_MSIP, 32'h0);
    axi_write(IRQ_CLAIM, 32'h2);
    axi_write(IRQ_CLAIM, 32'h3);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b0) begin
      $display("FAIL pri_idle got %0b want 0", int_req);
      n_bad++;
    end
  endtask

  task automatic test_replay;
    axi_write(IRQ_ENABLE, 32'h10);
    ext_irq[1] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    axi_read(IRQ_CLAIM, d);
    n_cmp++;
    if (d !== 32'h4) begin
      $display("FAIL rep_claim got %0h want 4", d);
      n_bad++;
    end
    ext_irq[1] = 1'b0;
    repeat (2) @(negedge clk);
    ext_irq[1] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b0) begin
      $display("FAIL rep_held got %0b want 0", int_req);
      n_bad++;
    end
    axi_write(IRQ_CLAIM, 32'h4);
    @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 5'd4) begin
      $display("FAIL rep_replay got %0b/%0d want 1/4", int_req, int_id);
      n_bad++;
    end
    axi_read(IRQ_PENDING, d);
    n_cmp++;
    if (d !== 32'h10) begin
      $display("FAIL rep_pending got %0h want 10", d);
      n_bad++;
    end
    ext_irq[1] = 1'b0;
    repeat (2) @(negedge clk);
    ext_irq[1] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    axi_read(IRQ_CLAIM, d);
    n_cmp++;
    if (d !== 32'h4) begin
      $display("FAIL rep_claim2 got %0h want 4", d);
      n_bad++;
    end
    axi_write(IRQ_CLAIM, 32'h4);
    repeat (2) @(negedge clk);
    axi_read(IRQ_PENDING, d);
    n_cmp++;
    if (d !== 32'h0 || int_req !== 1'b0) begin
      $display("FAIL rep_merged got %0h/%0b want 0/0", d, int_req);
      n_bad++;
    end
    ext_irq[1] = 1'b0;
  endtask

  task automatic test_illegal;
    axi_read(IRQ_CLAIM, d);
    n_cmp++;
    if (d !== 32'h0) begin
      $display("FAIL ill_empty got %0h want 0", d);
      n_bad++;
    end
    axi_write(IRQ_ENABLE, 32'h08);
    ext_irq[0] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    axi_read(IRQ_CLAIM, d);
    n_cmp++;
    if (d !== 32'h3) begin
      $display("FAIL ill_claim got %0h want 3", d);
      n_bad++;
    end
    ext_irq[0] = 1'b0;
    axi_write(IRQ_CLAIM, 32'h5);
    axi_write(IRQ_CLAIM, 32'h0);
    axi_write(IRQ_CLAIM, 32'h1F);
    ext_irq[0] = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    axi_read(IRQ_PENDING, d);
    n_cmp++;
    if (d !== 32'h0) begin
      $display("FAIL ill_nochange got %0h want 0", d);
      n_bad++;
    end
    axi_write(IRQ_CLAIM, 32'h3);
    repeat (2) @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 5'd3) begin
      $display("FAIL ill_replay got %0b/%0d want 1/3", int_req, int_id);
      n_bad++;
    end
    axi_read(IRQ_CLAIM, d);
    axi_write(IRQ_CLAIM, 32'h3);
    ext_irq[0] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_mask;
    axi_write(IRQ_ENABLE, 32'h0);
    ext_irq[2] = 1'b1;
    repeat (LAT) @(negedge clk);
    axi_read(IRQ_PENDING, d);
    n_cmp++;
    if (d !== 32'h0) begin
      $display("FAIL msk_latency got %0h want 0", d);
      n_bad++;
    end
    axi_read(IRQ_PENDING, d);
    n_cmp++;
    if (d !== 32'h20) begin
      $display("FAIL msk_pending got %0h want 20", d);
      n_bad++;
    end
    n_cmp++;
    if (int_req !== 1'b0) begin
      $display("FAIL msk_masked got %0b want 0", int_req);
      n_bad++;
    end
    axi_write(IRQ_ENABLE, 32'h20);
    n_cmp++;
    if (int_req !== 1'b0) begin
      $display("FAIL msk_en_early got %0b want 0", int_req);
      n_bad++;
    end
    @(negedge clk);
    n_cmp++;
    if (int_req !== 1'b1 || int_id !== 5'd5) begin
      $display("FAIL msk_unmask got %0b/%0d want 1/5", int_req, int_id);
      n_bad++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    bus.awaddr = '0;
    bus.awvalid = 1'b0;
    bus.wdata = '0;
    bus.wvalid = 1'b0;
    bus.bready = 1'b1;
    bus.araddr = '0;
    bus.arvalid = 1'b0;
    bus.rready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_timer;
    test_reset_mid_claim;
    test_priority;
    test_replay;
    test_illegal;
    test_mask;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
